// File: rtl/slot_pkg.sv
// Shared types for the slot-machine controller: FSM state codes and payout classes.
// The state codes double as the LCD page select, so their values are fixed.
package slot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SPIN  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SHOW  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_PAIR = 2'd1,
        CLS_ALL  = 2'd2
    } pay_class_e;

    function automatic logic isBusy(input state_e s);
        return (s == ST_SPIN) || (s == ST_EVAL);
    endfunction

endpackage

// File: rtl/slot_reel.sv
// One reel: counts through 0..SYM_MAX in a fixed direction while running.
// A stop request wins over a coincident step, so the reel freezes on its pre-step symbol.
module slot_reel #(
    parameter int SYM_W   = 4,
    parameter int SYM_MAX = 9,
    parameter bit DIR     = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             arm_i,
    input  logic             step_i,
    input  logic             stop_i,
    output logic [SYM_W-1:0] sym_o
);

    logic             run_q, run_d;
    logic [SYM_W-1:0] sym_q, sym_d;

    // Up-counting reels wrap SYM_MAX->0, down-counting reels wrap 0->SYM_MAX.
    always_comb begin
        run_d = run_q;
        sym_d = sym_q;
        if (arm_i) begin
            run_d = 1'b1;
        end else if (stop_i) begin
            run_d = 1'b0;
        end else if (run_q && step_i) begin
            if (DIR) begin
                sym_d = (sym_q == SYM_W'(SYM_MAX)) ? '0 : sym_q + 1'b1;
            end else begin
                sym_d = (sym_q == '0) ? SYM_W'(SYM_MAX) : sym_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_q <= 1'b0;
            sym_q <= '0;
        end else begin
            run_q <= run_d;
            sym_q <= sym_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: coin credit, N-reel spin/stop sequencing, match scoring, payout.
// Credit saturates at CREDIT_MAX; every output comes straight from a register.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int N_REEL     = 3,
    parameter int SYM_W      = 4,
    parameter int SYM_MAX    = 9,
    parameter int CREDIT_W   = 7,
    parameter int CREDIT_MAX = 99,
    parameter int COST       = 1,
    parameter int PAY_ALL    = 10,
    parameter int PAY_PAIR   = 2,
    parameter int SPIN_DIV   = 250000,
    parameter int SHOW_CYC   = 50000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    C_IN,
    input  logic                    GAME_START,
    input  logic                    SBTN,
    output logic [CREDIT_W-1:0]     CREDIT,
    output logic [N_REEL*SYM_W-1:0] REEL,
    output logic [2:0]              STATE,
    output logic [CREDIT_W-1:0]     WIN_AMT,
    output logic                    WIN_PULSE,
    output logic                    BUSY
);

    localparam int IDX_W  = $clog2(N_REEL);
    localparam int DIV_W  = $clog2(SPIN_DIV + 1);
    localparam int SHOW_W = $clog2(SHOW_CYC + 1);
    localparam int SUM_W  = CREDIT_W + 2;

    state_e state_q, state_d;

    logic                coinPrev_q, startPrev_q, sbtnPrev_q;
    logic                coinEv, startEv, sbtnEv;
    logic [DIV_W-1:0]    divCnt_q;
    logic [SHOW_W-1:0]   showCnt_q;
    logic                stepTick, showDone;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] winAmt_q, winAmt_d;
    logic                winPulse_q, winPulse_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    stopIdx_q, stopIdx_d;
    logic                creditOk, gameGo, lastStop;
    logic [SUM_W-1:0]    creditSum;
    logic [N_REEL-1:0]   reelStop;
    logic [SYM_W-1:0]    reelSym [N_REEL];
    logic                allEq, anyPair;
    pay_class_e          payClass;
    logic [CREDIT_W-1:0] payout;

    assign coinEv   = C_IN & ~coinPrev_q;
    assign startEv  = GAME_START & ~startPrev_q;
    assign sbtnEv   = SBTN & ~sbtnPrev_q;
    assign creditOk = credit_q >= CREDIT_W'(COST);
    assign gameGo   = (state_q == ST_READY) && startEv && creditOk;
    assign lastStop = (state_q == ST_SPIN) && sbtnEv && (stopIdx_q == IDX_W'(N_REEL - 1));
    assign stepTick = (state_q == ST_SPIN) && (divCnt_q == DIV_W'(SPIN_DIV - 1));
    assign showDone = (state_q == ST_SHOW) && (showCnt_q == SHOW_W'(SHOW_CYC - 1));

    // Input edge detectors, reel-step prescaler and result-display timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            coinPrev_q  <= 1'b0;
            startPrev_q <= 1'b0;
            sbtnPrev_q  <= 1'b0;
            divCnt_q    <= '0;
            showCnt_q   <= '0;
        end else begin
            coinPrev_q  <= C_IN;
            startPrev_q <= GAME_START;
            sbtnPrev_q  <= SBTN;
            divCnt_q    <= (state_q != ST_SPIN || stepTick) ? '0 : divCnt_q + 1'b1;
            showCnt_q   <= (state_q != ST_SHOW || showDone) ? '0 : showCnt_q + 1'b1;
        end
    end

    // The all-equal class takes priority over any pair.
    always_comb begin
        allEq   = 1'b1;
        anyPair = 1'b0;
        for (int i = 1; i < N_REEL; i++) begin
            if (reelSym[i] != reelSym[0]) allEq = 1'b0;
        end
        for (int i = 0; i < N_REEL; i++) begin
            for (int j = i + 1; j < N_REEL; j++) begin
                if (reelSym[i] == reelSym[j]) anyPair = 1'b1;
            end
        end
        payClass = allEq ? CLS_ALL : (anyPair ? CLS_PAIR : CLS_NONE);
        case (payClass)
            CLS_ALL:  payout = CREDIT_W'(PAY_ALL);
            CLS_PAIR: payout = CREDIT_W'(PAY_PAIR);
            default:  payout = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (creditOk) state_d = ST_READY;
            end
            ST_READY: begin
                if (!creditOk) begin
                    state_d = ST_IDLE;
                end else if (startEv) begin
                    state_d = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (lastStop) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (showDone || startEv) state_d = creditOk ? ST_READY : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Coin, game charge and payout are folded into one sum so a coin is never lost
    // on a start or evaluation cycle; saturation is applied last.
    always_comb begin
        creditSum = SUM_W'(credit_q) + SUM_W'(coinEv);
        if (state_q == ST_EVAL) begin
            creditSum = creditSum + SUM_W'(payout);
        end else if (gameGo) begin
            creditSum = creditSum - SUM_W'(COST);
        end
        credit_d = (creditSum > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX)
                                                    : creditSum[CREDIT_W-1:0];

        winAmt_d = winAmt_q;
        if (gameGo) begin
            winAmt_d = '0;
        end else if (state_q == ST_EVAL) begin
            winAmt_d = payout;
        end
        winPulse_d = (state_q == ST_EVAL) && (payout != '0);
        busy_d     = isBusy(state_d);

        stopIdx_d = stopIdx_q;
        if (gameGo) begin
            stopIdx_d = '0;
        end else if ((state_q == ST_SPIN) && sbtnEv && !lastStop) begin
            stopIdx_d = stopIdx_q + 1'b1;
        end

        reelStop = '0;
        for (int i = 0; i < N_REEL; i++) begin
            reelStop[i] = (state_q == ST_SPIN) && sbtnEv && (stopIdx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credit_q   <= '0;
            winAmt_q   <= '0;
            winPulse_q <= 1'b0;
            busy_q     <= 1'b0;
            stopIdx_q  <= '0;
        end else begin
            credit_q   <= credit_d;
            winAmt_q   <= winAmt_d;
            winPulse_q <= winPulse_d;
            busy_q     <= busy_d;
            stopIdx_q  <= stopIdx_d;
        end
    end

    // Even reels count up, odd reels count down.
    for (genvar i = 0; i < N_REEL; i++) begin : g_reel
        slot_reel #(
            .SYM_W  (SYM_W),
            .SYM_MAX(SYM_MAX),
            .DIR    ((i % 2) == 0)
        ) u_reel (
            .CLK   (CLK),
            .RST   (RST),
            .arm_i (gameGo),
            .step_i(stepTick),
            .stop_i(reelStop[i]),
            .sym_o (reelSym[i])
        );
        assign REEL[i*SYM_W +: SYM_W] = reelSym[i];
    end

    assign CREDIT    = credit_q;
    assign STATE     = state_q;
    assign WIN_AMT   = winAmt_q;
    assign WIN_PULSE = winPulse_q;
    assign BUSY      = busy_q;

endmodule
